// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient controller slice.
// Holds the controller state encoding, the tap MACC latency used to size
// the default output flush window, default tap geometry, and a helper that
// sizes the beat/flush counters.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    ARMED = 3'd3,
    SWAP  = 3'd4,
    FLUSH = 3'd5
  } fir_state_e;

  // Pipeline depth of one tap multiply-accumulate.
  localparam int MACC_LAT  = 3;
  localparam int DEF_NTAPS = 16;
  localparam int DEF_COEFW = 18;

  // Counter width able to hold max(ntaps, flush) inclusive.
  function automatic int cnt_width(input int ntaps, input int flush);
    int m;
    m = (ntaps > flush) ? ntaps : flush;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register pair for the tap chain.
// The shadow bank is written one coefficient at a time; a swap strobe copies
// the whole shadow bank into the active bank in a single cycle.
// Ports:
//   clk, reset      clock, synchronous active-low reset (clears both banks)
//   wr_en/wr_addr   shadow write strobe and tap index
//   wr_data         coefficient to store
//   swap            copy shadow -> active on this edge
//   coef_out        active bank, tap k at [k*COEFW +: COEFW]
module fir_coef_bank #(
  parameter int NTAPS = 16,
  parameter int COEFW = 18,
  parameter int AW    = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [COEFW-1:0]       wr_data,
  input  logic                   swap,
  output logic [NTAPS*COEFW-1:0] coef_out
);

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic [COEFW-1:0] shadow_q;
    logic [COEFW-1:0] active_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        if (wr_en && (wr_addr == AW'(k))) shadow_q <= wr_data;
        if (swap) active_q <= shadow_q;
      end
    end

    assign coef_out[k*COEFW +: COEFW] = active_q;
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient configuration controller for the systolic FIR tap chain.
// Loads a coefficient set from a valid/ready stream into a shadow bank,
// checks its length, and on commit swaps it into the active bank feeding all
// taps. The filter output is masked while products mixing old and new
// coefficients drain out of the MACC pipeline.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   s_coef_data/valid/last     coefficient stream (beat 0 -> tap 0)
//   s_coef_ready               stream ready (registered)
//   commit                     activate the armed shadow set
//   coef_out                   active bank, tap k at [k*COEFW +: COEFW]
//   out_valid                  filter output trustworthy
//   swap_done                  one-cycle pulse when the flush completes
//   busy                       controller not idle
//   err_len                    sticky: last set had the wrong length
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS     = DEF_NTAPS,
  parameter int COEFW     = DEF_COEFW,
  parameter int FLUSH_CYC = NTAPS + MACC_LAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COEFW-1:0]       s_coef_data,
  input  logic                   s_coef_valid,
  input  logic                   s_coef_last,
  output logic                   s_coef_ready,
  input  logic                   commit,
  output logic [NTAPS*COEFW-1:0] coef_out,
  output logic                   out_valid,
  output logic                   swap_done,
  output logic                   busy,
  output logic                   err_len
);

  localparam int              CNTW     = cnt_width(NTAPS, FLUSH_CYC);
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NTAPS - 1);
  localparam logic [CNTW-1:0] FLUSH_LD = CNTW'(FLUSH_CYC - 1);

  fir_state_e      state, state_n;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] fcnt;
  logic            ready_q, out_valid_q, swap_done_q, busy_q, err_q;

  logic            accept;
  logic            wr_en;
  logic [CNTW-1:0] wr_addr;
  logic            set_err, clr_err;

  assign accept = s_coef_valid && ready_q;

  // Next-state and shadow write decode.
  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    wr_addr = cnt;
    set_err = 1'b0;
    clr_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          clr_err = 1'b1;
          if (NTAPS == 1) begin
            // Single-tap set: the first beat is also the final slot.
            if (s_coef_last) begin
              state_n = ARMED;
            end else begin
              set_err = 1'b1;
              state_n = DRAIN;
            end
          end else if (s_coef_last) begin
            set_err = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (s_coef_last) begin
            if (cnt == LAST_IDX) begin
              state_n = ARMED;
            end else begin
              set_err = 1'b1;
              state_n = IDLE;
            end
          end else if (cnt == LAST_IDX) begin
            // Bank full without last: swallow the rest of the set.
            set_err = 1'b1;
            state_n = DRAIN;
          end
        end
      end
      DRAIN: if (accept && s_coef_last) state_n = IDLE;
      ARMED: if (commit) state_n = SWAP;
      SWAP:  state_n = FLUSH;
      FLUSH: if (fcnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      fcnt        <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      swap_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      ready_q     <= (state_n == IDLE) || (state_n == LOAD) || (state_n == DRAIN);
      busy_q      <= (state_n != IDLE);
      swap_done_q <= 1'b0;

      // A length error on the same beat that clears the flag wins.
      if (set_err)      err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;

      if (accept && (state == IDLE))      cnt <= CNTW'(1);
      else if (accept && (state == LOAD)) cnt <= cnt + CNTW'(1);

      unique case (state)
        // Masking starts the cycle after commit is seen, so the window is
        // exactly FLUSH_CYC+1 cycles even when out_valid was already high.
        ARMED: if (commit) out_valid_q <= 1'b0;
        SWAP: begin
          out_valid_q <= 1'b0;
          fcnt        <= FLUSH_LD;
        end
        FLUSH: begin
          if (fcnt == '0) begin
            out_valid_q <= 1'b1;
            swap_done_q <= 1'b1;
          end else begin
            fcnt <= fcnt - CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  fir_coef_bank #(
    .NTAPS (NTAPS),
    .COEFW (COEFW),
    .AW    (CNTW)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (s_coef_data),
    .swap     (state == SWAP),
    .coef_out (coef_out)
  );

  assign s_coef_ready = ready_q;
  assign out_valid    = out_valid_q;
  assign swap_done    = swap_done_q;
  assign busy         = busy_q;
  assign err_len      = err_q;

endmodule
